// File: rtl/stream_arbiter.sv
`timescale 1ns/1ps
// stream_arbiter
//   Packet-granular round-robin arbiter sharing one AXI-Stream output between
//   NUM_SRC upstream sources. A source is locked from grant until its tlast
//   beat is accepted, so packets never interleave. The shared output is driven
//   from a registered stage.
//
// Handshake: a beat moves across an interface in any cycle where tvalid and
//   tready are both 1. A source holds tvalid/tdata/tlast until that happens;
//   this block likewise holds m_tvalid/m_tdata/m_tlast while m_tready=0.
//   m_tvalid is only lowered after a handshake, or by reset.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   arb_en             permit new grants (sampled in IDLE only)
//   src_mask           per-source grant enable (sampled in IDLE only)
//   s_tdata/s_tvalid/s_tlast/s_tready   source streams, source i at slice i
//   m_tdata/m_tvalid/m_tlast/m_tready   shared registered output stream
//   grant_id           index of the locked source, holds when idle
//   busy               1 while LOCKED (FSM state observation)
//   pkt_done           one-cycle pulse after the granted tlast beat is accepted
module stream_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      arb_en,
  input  logic [NUM_SRC-1:0]        src_mask,
  input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]        s_tvalid,
  input  logic [NUM_SRC-1:0]        s_tlast,
  output logic [NUM_SRC-1:0]        s_tready,
  output logic [DATA_W-1:0]         m_tdata,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  input  logic                      m_tready,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      pkt_done
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     last_grant, last_grant_nxt, grant_nxt;
  logic [NUM_SRC-1:0]  req;
  logic [ID_W-1:0]     rr_pick;
  logic                rr_found;
  logic                load;
  logic                accept;
  logic                sel_valid;
  logic                sel_last;
  logic [DATA_W-1:0]   sel_data;

  // Round-robin search: first pass covers indices above last_grant, second
  // pass wraps to indices at or below it, so the last served source is last.
  always_comb begin
    req      = s_tvalid & src_mask;
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!rr_found && req[i] && (ID_W'(i) > last_grant)) begin
        rr_found = 1'b1;
        rr_pick  = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!rr_found && req[i] && (ID_W'(i) <= last_grant)) begin
        rr_found = 1'b1;
        rr_pick  = ID_W'(i);
      end
    end
  end

  // Mux of the granted source's stream signals.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_valid = s_tvalid[i];
        sel_last  = s_tlast[i];
        sel_data  = s_tdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // The output register can take a new beat when empty or being drained.
  assign load   = !m_tvalid || m_tready;
  assign busy   = (state == LOCKED);
  assign accept = busy && load && sel_valid;

  always_comb begin
    s_tready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s_tready[i] = busy && load && (grant_id == ID_W'(i));
    end
  end

  // Next-state logic. arb_en and src_mask only matter in IDLE.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_id;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (arb_en && rr_found) begin
          grant_nxt = rr_pick;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && sel_last) begin
          last_grant_nxt = grant_id;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_SRC - 1);
      grant_id   <= '0;
      pkt_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant_id   <= grant_nxt;
      pkt_done   <= accept && sel_last;
    end
  end

  // Output register: loads on accept, empties when drained with no new beat,
  // otherwise holds (stall).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
    end else if (load) begin
      m_tvalid <= accept;
      if (accept) begin
        m_tdata <= sel_data;
        m_tlast <= sel_last;
      end
    end
  end

endmodule

// File: tb/tb_stream_arbiter.sv
`timescale 1ns/1ps
module tb_stream_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           reset;
  logic           arb_en;
  logic [N-1:0]   src_mask;
  logic [N*W-1:0] s_tdata;
  logic [N-1:0]   s_tvalid;
  logic [N-1:0]   s_tlast;
  logic [N-1:0]   s_tready;
  logic [W-1:0]   m_tdata;
  logic           m_tvalid;
  logic           m_tlast;
  logic           m_tready;
  logic [1:0]     grant_id;
  logic           busy;
  logic           pkt_done;

  always #5 clk = ~clk;

  stream_arbiter #(.NUM_SRC(N), .DATA_W(W)) dut (
    .clk(clk), .reset(reset), .arb_en(arb_en), .src_mask(src_mask),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .grant_id(grant_id), .busy(busy), .pkt_done(pkt_done)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- source state ----------------
  logic [W:0]   src_q [N][$];    // bit W = tlast
  logic [N-1:0] hold;
  logic [N-1:0] acc_dut;
  int           acc_cnt [N];
  int           valid_pct;
  int           rdy_pct;
  int           tot_pushed;
  int           tot_seen;

  // ---------------- reference model ----------------
  // Abstract view: locked flag + granted source, output register occupancy,
  // and a queue of beats that must appear downstream in order.
  bit         md_locked;
  int         md_gid;
  int         md_last;
  bit         md_ovalid;
  bit         md_done;
  logic [W:0] exp_q [$];
  int         grant_log [$];
  int         exp_g [$];
  int         busy_cnt;
  int         done_cnt;
  bit         prev_stall;
  logic [W-1:0] prev_data;
  logic       prev_last;

  function automatic int rr_next(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    md_locked  = 1'b0;
    md_gid     = 0;
    md_last    = N - 1;
    md_ovalid  = 1'b0;
    md_done    = 1'b0;
    prev_stall = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic add_pkt(input int s, input int len, input logic [W-1:0] base);
    for (int b = 0; b < len; b++) begin
      src_q[s].push_back({(b == len - 1), base + W'(b)});
    end
    tot_pushed += len;
  endtask

  task automatic drive();
    logic [W:0] f;
    for (int i = 0; i < N; i++) begin
      if (acc_dut[i]) begin
        void'(src_q[i].pop_front());
        hold[i] = 1'b0;
        acc_cnt[i]++;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        f = src_q[i][0];
        s_tdata[i*W +: W] = f[W-1:0];
        s_tlast[i]        = f[W];
        if (!hold[i]) hold[i] = ($urandom_range(0, 99) < valid_pct);
        s_tvalid[i] = hold[i];
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
        hold[i]     = 1'b0;
      end
    end
    m_tready = ($urandom_range(0, 99) < rdy_pct);
  endtask

  // One clock: compare at negedge, advance model, drive after posedge.
  task automatic tick();
    logic [N-1:0] exp_rdy;
    logic [W:0]   e;
    bit           room;
    bit           nx_locked;
    int           nx_gid;
    int           nx_last;
    bit           nx_ovalid;
    bit           nx_done;
    int           p;
    @(negedge clk);
    room    = !md_ovalid || m_tready;
    exp_rdy = (md_locked && room) ? (N'(1) << md_gid) : '0;
    check("s_tready", 64'(s_tready), 64'(exp_rdy));
    check("busy",     64'(busy),     64'(md_locked));
    check("grant_id", 64'(grant_id), 64'(md_gid));
    check("pkt_done", 64'(pkt_done), 64'(md_done));
    check("m_tvalid", 64'(m_tvalid), 64'(md_ovalid));
    if (prev_stall) begin
      check("hold_data", 64'(m_tdata), 64'(prev_data));
      check("hold_last", 64'(m_tlast), 64'(prev_last));
    end
    if (m_tvalid && m_tready) begin
      tot_seen++;
      if (exp_q.size() == 0) begin
        check("extra_beat", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("beat", 64'({m_tlast, m_tdata}), 64'(e));
      end
    end
    prev_stall = m_tvalid && !m_tready;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
    if (busy) busy_cnt++;
    if (pkt_done) done_cnt++;
    acc_dut = s_tvalid & s_tready;

    nx_locked = md_locked;
    nx_gid    = md_gid;
    nx_last   = md_last;
    nx_ovalid = md_ovalid;
    nx_done   = 1'b0;
    if (md_locked) begin
      if (s_tvalid[md_gid] && room) begin
        exp_q.push_back({s_tlast[md_gid], s_tdata[md_gid*W +: W]});
        nx_ovalid = 1'b1;
        if (s_tlast[md_gid]) begin
          nx_locked = 1'b0;
          nx_last   = md_gid;
          nx_done   = 1'b1;
        end
      end else if (room) begin
        nx_ovalid = 1'b0;
      end
    end else begin
      if (room) nx_ovalid = 1'b0;
      p = rr_next(s_tvalid & src_mask, md_last);
      if (arb_en && p >= 0) begin
        nx_locked = 1'b1;
        nx_gid    = p;
        grant_log.push_back(p);
      end
    end
    @(posedge clk);
    md_locked = nx_locked;
    md_gid    = nx_gid;
    md_last   = nx_last;
    md_ovalid = nx_ovalid;
    md_done   = nx_done;
    #1;
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_s_tready", 64'(s_tready), 64'(0));
    check("rst_busy",     64'(busy),     64'(0));
    check("rst_pkt_done", 64'(pkt_done), 64'(0));
    check("rst_grant_id", 64'(grant_id), 64'(0));
    check("rst_m_tdata",  64'(m_tdata),  64'(0));
    check("rst_m_tlast",  64'(m_tlast),  64'(0));
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      acc_cnt[i] = 0;
    end
    hold       = '0;
    acc_dut    = '0;
    s_tvalid   = '0;
    s_tlast    = '0;
    s_tdata    = '0;
    m_tready   = 1'b1;
    tot_pushed = 0;
    tot_seen   = 0;
    busy_cnt   = 0;
    done_cnt   = 0;
    grant_log.delete();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic bit drained(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) begin
      if (m[i] && src_q[i].size() > 0) return 1'b0;
    end
    return (exp_q.size() == 0) && !md_locked && !md_ovalid;
  endfunction

  task automatic wait_drain(input logic [N-1:0] m, input int budget, input string tag);
    int c;
    c = 0;
    while (c < budget && !drained(m)) begin
      tick();
      c++;
    end
    check({tag, "_drain_timeout"}, 64'(c >= budget), 64'(0));
  endtask

  task automatic check_grants(input string tag);
    check({tag, "_ngrants"}, 64'(grant_log.size()), 64'(exp_g.size()));
    for (int i = 0; i < exp_g.size() && i < grant_log.size(); i++) begin
      check({tag, "_grant"}, 64'(grant_log[i]), 64'(exp_g[i]));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int s;
    reset     = 1'b1;
    arb_en    = 1'b1;
    src_mask  = '1;
    s_tdata   = '0;
    s_tvalid  = '0;
    s_tlast   = '0;
    m_tready  = 1'b1;
    hold      = '0;
    acc_dut   = '0;
    valid_pct = 100;
    rdy_pct   = 100;
    do_reset();

    // Single source 2, 3-beat packet.
    add_pkt(2, 3, 32'hA0);
    wait_drain(4'b0100, 40, "t1");
    exp_g = {2};
    check_grants("t1");
    check("t1_busy_cycles", 64'(busy_cnt), 64'(3));
    check("t1_pkt_done",    64'(done_cnt), 64'(1));

    // All sources with two 2-beat packets each.
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) add_pkt(i, 2, W'(32'h100 * (i + 1) + 32'h10 * k));
    wait_drain(4'b1111, 100, "t2");
    exp_g = {0, 1, 2, 3, 0, 1, 2, 3};
    check_grants("t2");
    check("t2_busy_cycles", 64'(busy_cnt), 64'(16));
    check("t2_pkt_done",    64'(done_cnt), 64'(8));

    // Backpressure mid-packet.
    do_reset();
    add_pkt(1, 6, 32'hC0);
    repeat (3) tick();
    rdy_pct = 0;
    repeat (5) tick();
    rdy_pct = 100;
    wait_drain(4'b0010, 40, "t3");
    check("t3_beats",    64'(acc_cnt[1]), 64'(6));
    check("t3_seen",     64'(tot_seen),   64'(6));
    check("t3_pkt_done", 64'(done_cnt),   64'(1));

    // Source 2 masked off.
    do_reset();
    src_mask = 4'b1011;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) add_pkt(i, 1, W'(32'h200 + 32'h10 * i + k));
    wait_drain(4'b1011, 60, "t4");
    exp_g = {0, 1, 3, 0, 1, 3};
    check_grants("t4");
    check("t4_src2_left", 64'(src_q[2].size()), 64'(2));
    src_mask = '1;

    // arb_en cleared during source 1's 4-beat packet.
    do_reset();
    add_pkt(1, 4, 32'h10);
    tick();
    tick();
    arb_en = 1'b0;
    add_pkt(0, 2, 32'h300);
    add_pkt(2, 2, 32'h320);
    add_pkt(3, 2, 32'h330);
    repeat (12) tick();
    check("t5_idle_busy", 64'(busy), 64'(0));
    check("t5_one_grant", 64'(grant_log.size()), 64'(1));
    check("t5_busy_cycles", 64'(busy_cnt), 64'(4));
    arb_en = 1'b1;
    wait_drain(4'b1111, 60, "t5");
    exp_g = {1, 2, 3, 0};
    check_grants("t5");

    // Reset after beat 2 of a 4-beat packet; last_grant must be restored.
    do_reset();
    add_pkt(1, 1, 32'h400);
    wait_drain(4'b0010, 20, "t6a");
    add_pkt(3, 4, 32'h70);
    c = 0;
    while (acc_cnt[3] < 2 && c < 40) begin
      tick();
      c++;
    end
    check("t6_reach_beat2", 64'(acc_cnt[3]), 64'(2));
    do_reset();
    add_pkt(0, 1, 32'h80);
    add_pkt(3, 1, 32'h90);
    wait_drain(4'b1111, 30, "t6");
    exp_g = {0, 3};
    check_grants("t6");

    // Randomized traffic, config changes and backpressure.
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc % 50 == 0) begin
        valid_pct = $urandom_range(50, 100);
        rdy_pct   = $urandom_range(40, 100);
        src_mask  = N'($urandom_range(0, (1 << N) - 1));
      end
      if ($urandom_range(0, 29) == 0) arb_en = ~arb_en;
      if ($urandom_range(0, 2) == 0) begin
        s = $urandom_range(0, N - 1);
        if (src_q[s].size() < 8) add_pkt(s, $urandom_range(1, 4), $urandom);
      end
      tick();
    end
    arb_en    = 1'b1;
    src_mask  = '1;
    valid_pct = 100;
    rdy_pct   = 100;
    wait_drain(4'b1111, 400, "t7");
    check("t7_all_beats", 64'(tot_seen), 64'(tot_pushed));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stream_arbiter.md
Name: stream_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one AXI-Stream datapath (the stream processor input) between NUM_SRC upstream requesters.
- Locks onto one source from grant until that source's tlast beat, so packets never interleave.
- Drives the shared stream through a registered output stage.
- Provides enable and per-source mask configuration plus status outputs for the peripheral subsystem.

Parameters:
- NUM_SRC, 4, number of requesting stream sources (2..8)
- DATA_W, 32, tdata width in bits
- ID_W, $clog2(NUM_SRC), width of the grant index

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- arb_en  input  1  1 = new grants permitted; 0 = finish current packet, then hold in IDLE
- src_mask  input  NUM_SRC  per-source enable; bit i = 0 excludes source i from new grants
- s_tdata  input  NUM_SRC*DATA_W  source data, source i at bits [i*DATA_W +: DATA_W]
- s_tvalid  input  NUM_SRC  source valid
- s_tlast  input  NUM_SRC  source last-beat flag
- s_tready  output  NUM_SRC  source ready
- m_tdata  output  DATA_W  shared stream data (registered)
- m_tvalid  output  1  shared stream valid (registered)
- m_tlast  output  1  shared stream last (registered)
- m_tready  input  1  shared stream ready
- grant_id  output  ID_W  index of the locked source; holds the last value when idle
- busy  output  1  1 while in LOCKED
- pkt_done  output  1  one-cycle pulse when the tlast beat is accepted from the granted source

Behaviour:
- Reset (async assert, sync release): state=IDLE, last_grant=NUM_SRC-1 (so source 0 wins first), grant_id=0. m_tvalid=0, m_tdata=0, m_tlast=0, s_tready=0, busy=0, pkt_done=0.
- States:
  - IDLE: compute req = s_tvalid & src_mask. If arb_en=1 and req!=0, select the first set bit searching from last_grant+1 upward, wrapping modulo NUM_SRC. Register it into grant_id and go to LOCKED. Otherwise stay in IDLE.
  - LOCKED: only s_tready[grant_id] may be 1. All other s_tready bits are 0.
- Output register:
  - load = !m_tvalid | m_tready.
  - s_tready[grant_id] = LOCKED & load (combinational from m_tready).
  - Beat accepted when s_tvalid[g] & s_tready[g]. On accept: m_tdata/m_tlast take source g's values and m_tvalid=1.
  - If load=1 and no accept, m_tvalid goes to 0. If load=0, the register holds.
- Packet end: on accept with s_tlast[g]=1:
  - pkt_done=1 next cycle.
  - last_grant=g, state goes to IDLE next cycle.
  - Arbitration for the next packet runs in that IDLE cycle, giving one bubble cycle between packets.
  - The last beat may still sit in the output register while the next grant is computed.
- Latency: source beat to m_tvalid is 1 cycle. Request to first s_tready is 1 cycle (IDLE arbitration).
- Throughput: 1 beat/cycle within a packet while m_tready=1.
- Fairness:
  - A source that has just been served has the lowest priority in the next arbitration.
  - With all sources requesting continuously, grants follow 0,1,2,3,0...
- arb_en or src_mask changes during LOCKED have no effect on the current packet. Both are sampled only in IDLE.
- s_tvalid dropping mid-packet: stay LOCKED and wait; no timeout.
- Single-beat packet (tvalid & tlast on the first beat): LOCKED for exactly one accept cycle, then IDLE.
- busy=1 for exactly the LOCKED cycles.
- Reset asserted mid-packet:
  - Immediate return to reset values. The partial packet is dropped.
  - Downstream sees m_tvalid fall without tlast; this is acceptable by system rule.
- m_tvalid must never drop without a handshake except on reset. m_tdata/m_tlast must be stable while m_tvalid=1 and m_tready=0.

Test Plan:
- Single source 2 sends a 3-beat packet (0xA0, 0xA1, 0xA2 with tlast), m_tready=1:
  - grant_id=2 one cycle after tvalid.
  - m_tdata 0xA0..0xA2 on consecutive cycles.
  - pkt_done pulses once; busy high for 3 cycles.
- All 4 sources hold 2-beat packets continuously:
  - Grant order 0,1,2,3,0.
  - One idle cycle between packets.
  - No beats interleaved across sources.
- Backpressure: m_tready=0 for 5 cycles mid-packet:
  - m_tdata/m_tvalid/m_tlast hold stable.
  - s_tready[g]=0 during the stall.
  - No beat is lost or duplicated after release.
- src_mask=4'b1011 with all sources requesting: source 2 is never granted; order 0,1,3,0.
- arb_en cleared during source 1's 4-beat packet: the packet completes, then busy=0 and no new grant while requests are pending; setting arb_en=1 resumes grants at source 2.
- Reset asserted after beat 2 of a 4-beat packet: m_tvalid=0 and s_tready=0 in the same cycle; after release, source 0 wins first if requesting.
